// File: rtl/glcd_bus_ctrl.sv
// Graphic-LCD parallel bus controller: FIFO-buffered command/data transactions
// replayed with programmable setup/strobe/hold timing. Define GLCD_READ_EN for LCD reads.
module glcd_bus_ctrl #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int T_SETUP    = 2,
   parameter int T_PULSE    = 4,
   parameter int T_HOLD     = 2,
   parameter int RST_CYCLES = 1000
) (
   input  logic                        clkin_sys,
   input  logic                        reset,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic                        wr_dc,
   input  logic                        wr_rd,
   input  logic [DATA_W-1:0]           wr_data,
   output logic                        rd_valid,
   output logic [DATA_W-1:0]           rd_data,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        lcd_csn,
   output logic                        lcd_d_cn,
   output logic                        lcd_wen,
   output logic                        lcd_e_rdn,
   output logic                        lcd_en,
   output logic                        lcd_rstn,
   output logic [DATA_W-1:0]           lcd_data_o,
   output logic                        lcd_data_oe,
   input  logic [DATA_W-1:0]           lcd_data_i
);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int T_MAX  = (T_SETUP > T_PULSE) ? ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)
                                               : ((T_PULSE > T_HOLD) ? T_PULSE : T_HOLD);
   localparam int CNT_W  = $clog2(T_MAX) + 1;
   localparam int INIT_W = $clog2(RST_CYCLES) + 1;
`ifdef GLCD_READ_EN
   localparam int ENT_W  = DATA_W + 2;
`else
   localparam int ENT_W  = DATA_W + 1;
`endif

   localparam logic [2:0] S_INIT  = 3'd0;
   localparam logic [2:0] S_IDLE  = 3'd1;
   localparam logic [2:0] S_SETUP = 3'd2;
   localparam logic [2:0] S_PULSE = 3'd3;
   localparam logic [2:0] S_HOLD  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [INIT_W-1:0] initCnt_q, initCnt_d;
   logic [ENT_W-1:0]  fifoMem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wrPtr_q, rdPtr_q;
   logic [PTR_W:0]    count_q, count_d;
   logic [ENT_W-1:0]  pushEntry, headEntry;
   logic              push, pop;
   logic              entDc_q, entRd;
   logic [DATA_W-1:0] entData_q;
   logic              csnD, dcD, wenD, rstnD, oeD;
   logic [DATA_W-1:0] dataD;
   logic              lcdCsn_q, lcdDcn_q, lcdWen_q, lcdEn_q, lcdRstn_q, lcdOe_q;
   logic [DATA_W-1:0] lcdData_q;
   logic              wrReady_q, busy_q;

   assign push      = wr_valid && wrReady_q;
   assign pop       = (state_q == S_IDLE) && (count_q != '0);
   assign headEntry = fifoMem_q[rdPtr_q];
`ifdef GLCD_READ_EN
   assign pushEntry = {wr_rd, wr_dc, wr_data};
`else
   assign pushEntry = {wr_dc, wr_data};
`endif

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + (PTR_W+1)'(1);
      end else if (pop && !push) begin
         count_d = count_q - (PTR_W+1)'(1);
      end
   end

   // Each timed phase reloads its counter on entry and leaves when it reaches zero.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      initCnt_d = initCnt_q;
      case (state_q)
         S_INIT: begin
            if (initCnt_q == INIT_W'(RST_CYCLES - 1)) begin
               state_d = S_IDLE;
            end else begin
               initCnt_d = initCnt_q + INIT_W'(1);
            end
         end
         S_IDLE: begin
            if (pop) begin
               state_d = S_SETUP;
               cnt_d   = CNT_W'(T_SETUP - 1);
            end
         end
         S_SETUP: begin
            if (cnt_q == '0) begin
               state_d = S_PULSE;
               cnt_d   = CNT_W'(T_PULSE - 1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_PULSE: begin
            if (cnt_q == '0) begin
               state_d = S_HOLD;
               cnt_d   = CNT_W'(T_HOLD - 1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_HOLD: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   // Pin values follow the current state and are registered, so the bus lags the FSM by one cycle.
   always_comb begin
      csnD  = 1'b1;
      dcD   = 1'b0;
      wenD  = 1'b1;
      oeD   = 1'b0;
      dataD = '0;
      rstnD = (state_q != S_INIT);
      if (state_q == S_SETUP || state_q == S_PULSE || state_q == S_HOLD) begin
         csnD = 1'b0;
         dcD  = entDc_q;
         if (!entRd) begin
            oeD   = 1'b1;
            dataD = entData_q;
         end
         if (state_q == S_PULSE) begin
            wenD = entRd;
         end
      end
   end

   always_ff @(posedge clkin_sys) begin
      if (push) begin
         fifoMem_q[wrPtr_q] <= pushEntry;
      end
   end

   always_ff @(posedge clkin_sys or posedge reset) begin
      if (reset) begin
         state_q   <= S_INIT;
         cnt_q     <= '0;
         initCnt_q <= '0;
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         count_q   <= '0;
         entDc_q   <= 1'b0;
         entData_q <= '0;
         lcdCsn_q  <= 1'b1;
         lcdDcn_q  <= 1'b0;
         lcdWen_q  <= 1'b1;
         lcdEn_q   <= 1'b0;
         lcdRstn_q <= 1'b0;
         lcdData_q <= '0;
         lcdOe_q   <= 1'b0;
         wrReady_q <= 1'b0;
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         initCnt_q <= initCnt_d;
         count_q   <= count_d;
         if (push) begin
            wrPtr_q <= wrPtr_q + PTR_W'(1);
         end
         if (pop) begin
            rdPtr_q   <= rdPtr_q + PTR_W'(1);
            entDc_q   <= headEntry[DATA_W];
            entData_q <= headEntry[DATA_W-1:0];
         end
         lcdCsn_q  <= csnD;
         lcdDcn_q  <= dcD;
         lcdWen_q  <= wenD;
         lcdEn_q   <= rstnD;
         lcdRstn_q <= rstnD;
         lcdData_q <= dataD;
         lcdOe_q   <= oeD;
         wrReady_q <= (state_q != S_INIT) && (count_d != (PTR_W+1)'(FIFO_DEPTH));
         busy_q    <= (state_d != S_IDLE) || (count_d != '0);
      end
   end

`ifdef GLCD_READ_EN
   logic              entRd_q, rdnD, lcdRdn_q, rdValid_q;
   logic [DATA_W-1:0] rdData_q;

   assign entRd = entRd_q;
   assign rdnD  = !((state_q == S_PULSE) && entRd_q);

   // The read strobe's rising edge marks its last low cycle: capture the bus there.
   always_ff @(posedge clkin_sys or posedge reset) begin
      if (reset) begin
         entRd_q   <= 1'b0;
         lcdRdn_q  <= 1'b1;
         rdValid_q <= 1'b0;
         rdData_q  <= '0;
      end else begin
         if (pop) begin
            entRd_q <= headEntry[ENT_W-1];
         end
         lcdRdn_q  <= rdnD;
         rdValid_q <= !lcdRdn_q && rdnD;
         if (!lcdRdn_q && rdnD) begin
            rdData_q <= lcd_data_i;
         end
      end
   end

   assign lcd_e_rdn = lcdRdn_q;
   assign rd_valid  = rdValid_q;
   assign rd_data   = rdData_q;
`else
   logic unusedInputs;

   assign entRd        = 1'b0;
   assign lcd_e_rdn    = 1'b1;
   assign rd_valid     = 1'b0;
   assign rd_data      = '0;
   assign unusedInputs = ^{wr_rd, lcd_data_i};
`endif

   assign wr_ready    = wrReady_q;
   assign busy        = busy_q;
   assign fifo_level  = count_q;
   assign lcd_csn     = lcdCsn_q;
   assign lcd_d_cn    = lcdDcn_q;
   assign lcd_wen     = lcdWen_q;
   assign lcd_en      = lcdEn_q;
   assign lcd_rstn    = lcdRstn_q;
   assign lcd_data_o  = lcdData_q;
   assign lcd_data_oe = lcdOe_q;
endmodule

// File: tb/tb_glcd_bus_ctrl.sv
// Self-checking bench for glcd_bus_ctrl: a default 8-bit instance plus a 16-bit fast-timing instance,
// checked against a transaction-level bus monitor and a FIFO occupancy model.
module tb_glcd_bus_ctrl;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic       wrValid = 1'b0, wrDc = 1'b0, wrRd = 1'b0;
   logic [7:0] wrData = '0, lcdDataI = '0;
   logic       wrReady, rdValid, busy;
   logic [7:0] rdData, lcdDataO;
   logic [4:0] fifoLevel;
   logic       lcdCsn, lcdDcn, lcdWen, lcdErdn, lcdEn, lcdRstn, lcdOe;

   logic        wrValid16 = 1'b0, wrDc16 = 1'b0, wrRd16 = 1'b0;
   logic [15:0] wrData16 = '0, lcdDataI16 = '0;
   logic        wrReady16, rdValid16, busy16;
   logic [15:0] rdData16, lcdDataO16;
   logic [2:0]  fifoLevel16;
   logic        lcdCsn16, lcdDcn16, lcdWen16, lcdErdn16, lcdEn16, lcdRstn16, lcdOe16;

   int checks = 0;
   int failures = 0;

   glcd_bus_ctrl dut (
      .clkin_sys(clock), .reset(reset), .wr_valid(wrValid), .wr_ready(wrReady),
      .wr_dc(wrDc), .wr_rd(wrRd), .wr_data(wrData), .rd_valid(rdValid), .rd_data(rdData),
      .busy(busy), .fifo_level(fifoLevel), .lcd_csn(lcdCsn), .lcd_d_cn(lcdDcn),
      .lcd_wen(lcdWen), .lcd_e_rdn(lcdErdn), .lcd_en(lcdEn), .lcd_rstn(lcdRstn),
      .lcd_data_o(lcdDataO), .lcd_data_oe(lcdOe), .lcd_data_i(lcdDataI)
   );

   glcd_bus_ctrl #(.DATA_W(16), .FIFO_DEPTH(4), .T_SETUP(1), .T_PULSE(1), .T_HOLD(1),
                   .RST_CYCLES(4)) dut16 (
      .clkin_sys(clock), .reset(reset), .wr_valid(wrValid16), .wr_ready(wrReady16),
      .wr_dc(wrDc16), .wr_rd(wrRd16), .wr_data(wrData16), .rd_valid(rdValid16), .rd_data(rdData16),
      .busy(busy16), .fifo_level(fifoLevel16), .lcd_csn(lcdCsn16), .lcd_d_cn(lcdDcn16),
      .lcd_wen(lcdWen16), .lcd_e_rdn(lcdErdn16), .lcd_en(lcdEn16), .lcd_rstn(lcdRstn16),
      .lcd_data_o(lcdDataO16), .lcd_data_oe(lcdOe16), .lcd_data_i(lcdDataI16)
   );

   typedef struct {
      logic       dc;
      logic [7:0] data;
      int         len;
      int         wenStart;
      int         wenLen;
      int         rdnLen;
      bit         stable;
      bit         oeAll;
      bit         oeAny;
   } txn_t;

   txn_t obs[$];
   txn_t cur;
   bit   inTxn = 1'b0;
   int   rdPulses = 0;
   logic [7:0] lastRd = '0;

   // Bus monitor: folds every chip-select-low window of the main instance into one transaction record.
   always @(negedge clock) begin
      if (reset) begin
         inTxn = 1'b0;
      end else if (lcdCsn === 1'b0) begin
         if (!inTxn) begin
            inTxn      = 1'b1;
            cur        = '{default: 0};
            cur.stable = 1'b1;
            cur.oeAll  = 1'b1;
            cur.dc     = lcdDcn;
            cur.data   = lcdDataO;
         end
         cur.len++;
         if (lcdDcn !== cur.dc || lcdDataO !== cur.data) cur.stable = 1'b0;
         if (lcdWen === 1'b0) begin
            if (cur.wenLen == 0) cur.wenStart = cur.len;
            cur.wenLen++;
         end
         if (lcdErdn === 1'b0) cur.rdnLen++;
         if (lcdOe === 1'b1) cur.oeAny = 1'b1;
         else cur.oeAll = 1'b0;
      end else if (inTxn) begin
         inTxn = 1'b0;
         obs.push_back(cur);
      end
      if (!reset && rdValid === 1'b1) begin
         rdPulses++;
         lastRd = rdData;
      end
   end

   task automatic test_reset();
      int n;
      bit csnActive;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      checks++;
      if ({lcdCsn, lcdWen, lcdErdn, lcdDcn, lcdEn, lcdRstn, lcdOe} !== 7'b1110000) begin
         failures++;
         $display("[TB] FAIL reset_pins got=%b exp=1110000",
                  {lcdCsn, lcdWen, lcdErdn, lcdDcn, lcdEn, lcdRstn, lcdOe});
      end
      checks++;
      if ({wrReady, rdValid, busy} !== 3'b001) begin
         failures++; $display("[TB] FAIL reset_flags got=%b exp=001", {wrReady, rdValid, busy});
      end
      checks++;
      if (lcdDataO !== 8'h00 || rdData !== 8'h00) begin
         failures++; $display("[TB] FAIL reset_data got=%h/%h exp=00/00", lcdDataO, rdData);
      end
      checks++;
      if (fifoLevel !== 5'd0) begin
         failures++; $display("[TB] FAIL reset_level got=%0d exp=0", fifoLevel);
      end
      @(negedge clock) reset = 1'b0;
      n = 0;
      csnActive = 1'b0;
      do begin
         @(negedge clock);
         if (lcdCsn !== 1'b1) csnActive = 1'b1;
         if (lcdRstn === 1'b0) n++;
      end while (lcdRstn === 1'b0 && n < 1100);
      checks++;
      if (n != 1000) begin
         failures++; $display("[TB] FAIL init_rstn_low_cycles got=%0d exp=1000", n);
      end
      checks++;
      if ({lcdRstn, lcdEn, wrReady, busy} !== 4'b1110) begin
         failures++; $display("[TB] FAIL init_done got=%b exp=1110", {lcdRstn, lcdEn, wrReady, busy});
      end
      checks++;
      if (csnActive) begin
         failures++; $display("[TB] FAIL init_csn_quiet got=active exp=quiet");
      end
      checks++;
      if (wrReady16 !== 1'b1 || lcdRstn16 !== 1'b1) begin
         failures++; $display("[TB] FAIL init16_done got=%b%b exp=11", wrReady16, lcdRstn16);
      end
   endtask

   task automatic test_single_write();
      int lat, guard;
      txn_t t;
      obs.delete();
      @(negedge clock);
      wrValid = 1'b1; wrDc = 1'b0; wrRd = 1'b0; wrData = 8'h2C;
      @(negedge clock);
      wrValid = 1'b0;
      lat = 0;
      while (lcdCsn !== 1'b0 && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      checks++;
      if (lat != 2) begin
         failures++; $display("[TB] FAIL write_latency got=%0d exp=2", lat);
      end
      guard = 0;
      while (obs.size() == 0 && guard < 40) begin
         @(negedge clock); #1; guard++;
      end
      checks++;
      if (obs.size() != 1) begin
         failures++; $display("[TB] FAIL write_txn_count got=%0d exp=1", obs.size());
         return;
      end
      t = obs.pop_front();
      checks++;
      if (t.len != 8 || t.wenStart != 3 || t.wenLen != 4) begin
         failures++;
         $display("[TB] FAIL write_timing got=len%0d/wen@%0d+%0d exp=len8/wen@3+4", t.len, t.wenStart, t.wenLen);
      end
      checks++;
      if (t.dc !== 1'b0 || t.data !== 8'h2C || !t.stable || !t.oeAll || t.rdnLen != 0) begin
         failures++;
         $display("[TB] FAIL write_fields got=dc%b data%h stable%b oe%b rdn%0d exp=dc0 data2c stable1 oe1 rdn0",
                  t.dc, t.data, t.stable, t.oeAll, t.rdnLen);
      end
      checks++;
      if (busy !== 1'b0 || fifoLevel !== 5'd0) begin
         failures++; $display("[TB] FAIL write_idle got=busy%b lvl%0d exp=busy0 lvl0", busy, fifoLevel);
      end
   endtask

`ifdef GLCD_READ_EN
   task automatic test_read();
      int guard;
      txn_t t;
      obs.delete();
      rdPulses = 0;
      lcdDataI = 8'hA5;
      @(negedge clock);
      wrValid = 1'b1; wrDc = 1'b1; wrRd = 1'b1; wrData = 8'($urandom);
      @(negedge clock);
      wrValid = 1'b0; wrRd = 1'b0;
      guard = 0;
      while (obs.size() == 0 && guard < 40) begin
         @(negedge clock); #1; guard++;
      end
      checks++;
      if (obs.size() != 1) begin
         failures++; $display("[TB] FAIL read_txn_count got=%0d exp=1", obs.size());
         return;
      end
      t = obs.pop_front();
      checks++;
      if (t.rdnLen != 4 || t.wenLen != 0 || t.oeAny || t.dc !== 1'b1 || t.len != 8) begin
         failures++;
         $display("[TB] FAIL read_bus got=rdn%0d wen%0d oe%b dc%b len%0d exp=rdn4 wen0 oe0 dc1 len8",
                  t.rdnLen, t.wenLen, t.oeAny, t.dc, t.len);
      end
      checks++;
      if (rdPulses != 1 || lastRd !== 8'hA5) begin
         failures++; $display("[TB] FAIL read_result got=pulses%0d data%h exp=pulses1 dataa5", rdPulses, lastRd);
      end
   endtask
`else
   task automatic test_read();
      int guard;
      txn_t t;
      logic [7:0] d;
      obs.delete();
      rdPulses = 0;
      lcdDataI = 8'($urandom);
      d = 8'($urandom);
      @(negedge clock);
      wrValid = 1'b1; wrDc = 1'b1; wrRd = 1'b1; wrData = d;
      @(negedge clock);
      wrValid = 1'b0; wrRd = 1'b0;
      guard = 0;
      while (obs.size() == 0 && guard < 40) begin
         @(negedge clock); #1; guard++;
      end
      checks++;
      if (obs.size() != 1) begin
         failures++; $display("[TB] FAIL rd_ignored_count got=%0d exp=1", obs.size());
         return;
      end
      t = obs.pop_front();
      checks++;
      if (t.wenLen != 4 || t.rdnLen != 0 || !t.oeAll || t.data !== d || t.dc !== 1'b1) begin
         failures++;
         $display("[TB] FAIL rd_ignored_write got=wen%0d rdn%0d oe%b data%h dc%b exp=wen4 rdn0 oe1 data%h dc1",
                  t.wenLen, t.rdnLen, t.oeAll, t.data, t.dc, d);
      end
      checks++;
      if (rdPulses != 0 || rdData !== 8'h00) begin
         failures++; $display("[TB] FAIL rd_tied_off got=pulses%0d data%h exp=pulses0 data00", rdPulses, rdData);
      end
   endtask
`endif

   // Occupancy model: the LCD side takes one entry whenever it is free, then stays busy for
   // setup+pulse+hold+1 cycles; the FIFO holds at most 16 entries.
   task automatic test_back_to_back();
      logic [8:0] expQ[$];
      logic [8:0] e;
      int accepted, k, mLevel, nextPop, maxLvl, guard;
      bit r, pushM, popM;
      txn_t t;
      obs.delete();
      accepted = 0; k = 0; mLevel = 0; nextPop = 0; maxLvl = 0;
      @(negedge clock);
      wrDc = 1'($urandom); wrData = 8'($urandom); wrRd = 1'b0; wrValid = 1'b1;
      while ((accepted < 24 || mLevel > 0) && k < 1000) begin
         checks++;
         if (fifoLevel !== 5'(mLevel) || wrReady !== (mLevel != 16)) begin
            failures++;
            $display("[TB] FAIL fifo_model cyc%0d got=lvl%0d rdy%b exp=lvl%0d rdy%b",
                     k, fifoLevel, wrReady, mLevel, (mLevel != 16));
         end
         if (mLevel > maxLvl) maxLvl = mLevel;
         r     = wrReady;
         pushM = wrValid && (mLevel != 16);
         popM  = (mLevel > 0) && (k >= nextPop);
         if (popM) nextPop = k + 9;
         mLevel = mLevel + int'(pushM) - int'(popM);
         @(negedge clock);
         k++;
         if (wrValid && r) begin
            expQ.push_back({wrDc, wrData});
            accepted++;
            if (accepted < 24) begin
               wrDc = 1'($urandom); wrData = 8'($urandom);
            end else begin
               wrValid = 1'b0;
            end
         end
      end
      wrValid = 1'b0;
      checks++;
      if (accepted != 24 || maxLvl != 16) begin
         failures++; $display("[TB] FAIL fill_summary got=acc%0d max%0d exp=acc24 max16", accepted, maxLvl);
      end
      guard = 0;
      while (obs.size() < 24 && guard < 300) begin
         @(negedge clock); #1; guard++;
      end
      checks++;
      if (obs.size() != 24) begin
         failures++; $display("[TB] FAIL order_count got=%0d exp=24", obs.size());
      end
      while (obs.size() > 0 && expQ.size() > 0) begin
         t = obs.pop_front();
         e = expQ.pop_front();
         checks++;
         if ({t.dc, t.data} !== e || t.len != 8 || !t.stable) begin
            failures++;
            $display("[TB] FAIL order_entry got=%h len%0d exp=%h len8", {t.dc, t.data}, t.len, e);
         end
      end
   endtask

   task automatic test_wide_fast();
      int lat, len, wenLen, wenStart;
      bit dataOk, dcOk;
      lat = 0; len = 0; wenLen = 0; wenStart = 0; dataOk = 1'b1; dcOk = 1'b1;
      @(negedge clock);
      wrValid16 = 1'b1; wrDc16 = 1'b1; wrRd16 = 1'b0; wrData16 = 16'hBEEF;
      @(negedge clock);
      wrValid16 = 1'b0;
      while (lcdCsn16 !== 1'b0 && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      checks++;
      if (lat != 2) begin
         failures++; $display("[TB] FAIL wide_latency got=%0d exp=2", lat);
      end
      while (lcdCsn16 === 1'b0 && len < 20) begin
         len++;
         if (lcdWen16 === 1'b0) begin
            if (wenLen == 0) wenStart = len;
            wenLen++;
         end
         if (lcdDataO16 !== 16'hBEEF || lcdOe16 !== 1'b1) dataOk = 1'b0;
         if (lcdDcn16 !== 1'b1) dcOk = 1'b0;
         @(negedge clock);
      end
      checks++;
      if (len != 3 || wenLen != 1 || wenStart != 2) begin
         failures++;
         $display("[TB] FAIL wide_timing got=len%0d wen@%0d+%0d exp=len3 wen@2+1", len, wenStart, wenLen);
      end
      checks++;
      if (!dataOk || !dcOk) begin
         failures++; $display("[TB] FAIL wide_data got=data%b dc%b exp=data1 dc1", dataOk, dcOk);
      end
   endtask

   task automatic test_reset_mid();
      int n, guard;
      obs.delete();
      n = 0;
      @(negedge clock);
      wrValid = 1'b1; wrRd = 1'b0;
      while (n < 6) begin
         wrDc = 1'($urandom); wrData = 8'($urandom);
         if (wrReady === 1'b1) n++;
         @(negedge clock);
      end
      wrValid = 1'b0;
      guard = 0;
      while (lcdWen !== 1'b0 && guard < 30) begin
         @(negedge clock); guard++;
      end
      checks++;
      if (lcdWen !== 1'b0) begin
         failures++; $display("[TB] FAIL midreset_reach_pulse got=wen%b exp=wen0", lcdWen);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({lcdCsn, lcdWen, lcdErdn, lcdRstn, lcdEn, lcdOe, wrReady, busy} !== 8'b11100001) begin
         failures++;
         $display("[TB] FAIL midreset_pins got=%b exp=11100001",
                  {lcdCsn, lcdWen, lcdErdn, lcdRstn, lcdEn, lcdOe, wrReady, busy});
      end
      checks++;
      if (fifoLevel !== 5'd0 || lcdDataO !== 8'h00) begin
         failures++; $display("[TB] FAIL midreset_flush got=lvl%0d data%h exp=lvl0 data00", fifoLevel, lcdDataO);
      end
      repeat (2) @(negedge clock);
      reset = 1'b0;
      guard = 0;
      while (lcdRstn !== 1'b1 && guard < 1100) begin
         @(negedge clock); guard++;
      end
      repeat (200) @(negedge clock);
      #1;
      checks++;
      if (obs.size() != 0 || fifoLevel !== 5'd0 || busy !== 1'b0 || lcdRstn !== 1'b1) begin
         failures++;
         $display("[TB] FAIL midreset_no_stale got=txns%0d lvl%0d busy%b rstn%b exp=txns0 lvl0 busy0 rstn1",
                  obs.size(), fifoLevel, busy, lcdRstn);
      end
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_single_write();
      test_read();
      test_back_to_back();
      test_wide_fast();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
